// File: rtl/cdr_lock_ctrl.sv
// cdr_lock_ctrl: CDR charge-pump lock sequencer (IDLE/ACQ/TRACK/LOST) driven by windowed up/down imbalance.
// Optional macro CDR_LOCK_STATS_EN adds an 8-bit saturating lock_loss_cnt output.
module cdr_lock_ctrl #(
    parameter int WIN_LEN       = 64,
    parameter int CNT_W         = 8,
    parameter int LOCK_THRESH   = 4,
    parameter int LOCK_WINDOWS  = 4,
    parameter int UNLOCK_THRESH = 16,
    parameter int ICP_W         = 4,
    parameter int ICP_ACQ       = 12,
    parameter int ICP_TRK       = 3
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    up,
    input  logic                    down,
`ifdef CDR_LOCK_STATS_EN
    output logic [7:0]              lock_loss_cnt,
`endif
    output logic                    cp_en,
    output logic [ICP_W-1:0]        icp_code,
    output logic                    locked,
    output logic [1:0]              state,
    output logic signed [CNT_W:0]   win_diff
);
    localparam int WIN_W  = $clog2(WIN_LEN);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOST} state_t;

    state_t                r_state, w_next;
    logic [WIN_W-1:0]      r_win_cnt;
    logic [CNT_W-1:0]      r_up_cnt, r_dn_cnt, w_up_sum, w_dn_sum;
    logic [GOOD_W-1:0]     r_good_cnt, w_good_nxt;
    logic signed [CNT_W:0] w_diff;
    logic [CNT_W:0]        w_abs;
    logic                  w_win_end, w_good, w_lost, w_clr;

    // Sums include this cycle's pulses so the window-end diff covers all WIN_LEN cycles.
    assign w_up_sum  = (&r_up_cnt) ? r_up_cnt : r_up_cnt + CNT_W'(up);
    assign w_dn_sum  = (&r_dn_cnt) ? r_dn_cnt : r_dn_cnt + CNT_W'(down);
    assign w_diff    = $signed({1'b0, w_up_sum}) - $signed({1'b0, w_dn_sum});
    assign w_abs     = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_good    = w_abs <= (CNT_W+1)'(LOCK_THRESH);
    assign w_lost    = w_abs > (CNT_W+1)'(UNLOCK_THRESH);
    assign w_win_end = (r_state != IDLE) && (r_win_cnt == WIN_W'(WIN_LEN - 1));
    assign w_clr     = (r_state == IDLE) || w_win_end || (w_next != r_state);
    assign state     = r_state;

    always_comb begin
        w_next     = r_state;
        w_good_nxt = r_good_cnt;
        if (!enable) begin
            w_next     = IDLE;
            w_good_nxt = '0;
        end else begin
            case (r_state)
                IDLE:  w_next = ACQ;
                ACQ: begin
                    if (w_win_end) begin
                        w_good_nxt = w_good ? r_good_cnt + 1'b1 : '0;
                        if (w_good && r_good_cnt == GOOD_W'(LOCK_WINDOWS - 1)) begin
                            w_next     = TRACK;
                            w_good_nxt = '0;
                        end
                    end
                end
                TRACK: w_next = (w_win_end && w_lost) ? LOST : TRACK;
                LOST:  w_next = w_win_end ? ACQ : LOST;
                default: w_next = IDLE;
            endcase
        end
    end

    // Outputs decode the next state so they stay aligned with the registered state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_good_cnt <= '0;
            r_win_cnt  <= '0;
            r_up_cnt   <= '0;
            r_dn_cnt   <= '0;
            cp_en      <= 1'b0;
            icp_code   <= '0;
            locked     <= 1'b0;
            win_diff   <= '0;
        end else begin
            r_state    <= w_next;
            r_good_cnt <= w_good_nxt;
            r_win_cnt  <= w_clr ? '0 : r_win_cnt + 1'b1;
            r_up_cnt   <= w_clr ? '0 : w_up_sum;
            r_dn_cnt   <= w_clr ? '0 : w_dn_sum;
            cp_en      <= w_next != IDLE;
            icp_code   <= w_next == TRACK ? ICP_W'(ICP_TRK) : w_next == IDLE ? '0 : ICP_W'(ICP_ACQ);
            locked     <= w_next == TRACK;
            if (w_win_end)
                win_diff <= w_diff;
        end
    end

`ifdef CDR_LOCK_STATS_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            lock_loss_cnt <= '0;
        else if (r_state == TRACK && w_next == LOST && lock_loss_cnt != 8'hFF)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
`endif
endmodule

// File: doc/cdr_lock_ctrl.md
Name: cdr_lock_ctrl

Overview:
- Sequences the CDR charge-pump loop from the phase-detector `up`/`down` pulses.
- Measures up/down imbalance over fixed refclk windows.
- Steps the charge-pump current code from acquisition gain to tracking gain once the loop has settled.
- Declares lock, detects loss of lock and re-acquires.
- Sits between the phase detector and the charge pump in the top-level CDR; its `icp_code` sets the charge-pump current `ig`.

Parameters:
- WIN_LEN, 64, refclk cycles per measurement window (min 4).
- CNT_W, 8, width of the up/down window counters; saturating.
- LOCK_THRESH, 4, max |up_cnt-dn_cnt| for a window to count as "good".
- LOCK_WINDOWS, 4, consecutive good windows in ACQ needed to enter TRACK.
- UNLOCK_THRESH, 16, |diff| strictly above this in TRACK forces LOST.
- ICP_W, 4, width of charge-pump current code.
- ICP_ACQ, 12, current code in ACQ and LOST.
- ICP_TRK, 3, current code in TRACK.

Ports:
- refclk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run loop, 0 = park in IDLE.
- up  in  1  phase-detector up pulse, synchronous to refclk.
- down  in  1  phase-detector down pulse, synchronous to refclk.
- cp_en  out  1  charge-pump enable.
- icp_code  out  ICP_W  charge-pump current code.
- locked  out  1  lock indication.
- state  out  2  0=IDLE, 1=ACQ, 2=TRACK, 3=LOST.
- win_diff  out  CNT_W+1 signed  last window's up_cnt-dn_cnt.

Behaviour:
- Reset (async assert, sync release on refclk):
  - state=IDLE; cp_en=0, icp_code=0, locked=0, win_diff=0.
  - All counters 0.
- All outputs are registered. cp_en, icp_code and locked are pure functions of the registered state:
  - IDLE: 0/0/0.
  - ACQ: 1/ICP_ACQ/0.
  - TRACK: 1/ICP_TRK/1.
  - LOST: 1/ICP_ACQ/0.
- Window counter:
  - win_cnt runs 0..WIN_LEN-1 in ACQ/TRACK/LOST and wraps.
  - Held at 0 in IDLE.
  - Cleared on every state change.
- Pulse counting, each cycle in a non-IDLE state:
  - up_cnt += up; dn_cnt += down.
  - up and down both high in the same cycle: both counters increment.
  - Counters saturate at 2^CNT_W-1, no wrap.
- Window end (win_cnt==WIN_LEN-1):
  - diff = (up_cnt+up) - (dn_cnt+down), saturated counts, CNT_W+1-bit signed.
  - diff registered into win_diff the next cycle.
  - up_cnt and dn_cnt cleared to 0 the next cycle; that cycle's pulses start the new window.
- IDLE:
  - enable=1 → ACQ next cycle.
  - good_cnt=0.
- ACQ:
  - At window end, |diff|<=LOCK_THRESH increments good_cnt; otherwise good_cnt is cleared.
  - good_cnt reaching LOCK_WINDOWS → TRACK next cycle.
- TRACK:
  - At window end, |diff|>UNLOCK_THRESH → LOST next cycle; locked drops that same cycle.
  - |diff| in (LOCK_THRESH, UNLOCK_THRESH] is tolerated: stays in TRACK.
- LOST:
  - Holds for exactly one full window, diff ignored.
  - Then → ACQ with good_cnt=0.
- enable=0 in any state → IDLE next cycle, overriding any window-end transition in the same cycle. Counters and good_cnt are cleared.
- |diff| uses a full-width absolute value. The most negative value cannot occur because counts are ≤2^CNT_W-1.
- Reset asserted mid-window: immediate return to reset values; no partial window is reported.

Optional Feature:
- Macro: CDR_LOCK_STATS_EN.
- Defined:
  - Adds output lock_loss_cnt (8 bits).
  - Increments on each TRACK→LOST transition and saturates at 255.
  - Cleared only by rst_n; not cleared by enable=0.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then enable=1 at cycle 0 with up=down=0:
  - state=ACQ at cycle 1, icp_code=12.
  - Window ends at cycles 64, 128, 192, 256.
  - state=TRACK, locked=1, icp_code=3 at cycle 257.
- In ACQ, 10 up pulses in window 3, otherwise quiet:
  - win_diff=+10; good_cnt resets.
  - TRACK entered only after 4 further good windows (7 windows total).
- In TRACK, 20 down pulses in one window:
  - win_diff=-20.
  - locked=0, state=LOST the cycle after window end.
  - ACQ 64 cycles later, icp_code=12.
- In TRACK, 12 up pulses per window:
  - Stays TRACK, locked=1, win_diff=+12 each window.
- up=down=1 every cycle for a window:
  - up_cnt=dn_cnt=64, win_diff=0, counted as a good window.
- enable=0 on the same cycle as the window end that would complete lock → state=IDLE, cp_en=0, locked=0.
- rst_n low mid-TRACK → all outputs 0 immediately.
- With CDR_LOCK_STATS_EN: two forced losses → lock_loss_cnt=2.
